// File: rtl/alu_div.sv
// Unsigned restoring divider.
// A start request latches the operands; the divider then produces one
// quotient bit per clock, MSB first, and pulses done for one cycle when the
// quotient and remainder are ready. A zero divisor skips the iteration and
// reports dz with an all-ones quotient and the dividend as remainder.
module alu_div #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             dz,
    output logic             zout
);

    // Counter wide enough to hold WIDTH-1 for any WIDTH >= 1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Control state and iteration datapath.
    logic [1:0]       state_reg, state_next;
    logic [WIDTH-1:0] dvd_reg, dvd_next;   // dividend bits not yet consumed, quotient shifts in at LSB
    logic [WIDTH-1:0] dsr_reg, dsr_next;   // latched divisor
    logic [WIDTH-1:0] rem_reg, rem_next;   // partial remainder
    logic [CW-1:0]    cnt_reg, cnt_next;   // completed RUN steps

    // Result registers; only written when DONE is entered.
    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH-1:0] r_reg, r_next;
    logic             dz_reg, dz_next;
    logic             zout_reg, zout_next;

    // One restoring step on {partial remainder, dividend}.
    logic [WIDTH:0]   shifted_rem;
    logic [WIDTH:0]   trial;
    logic             trial_ok;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH:0]   dvd_shift;
    logic [WIDTH-1:0] dvd_step;
    logic             last_step;

    // Datapath for a single quotient bit: shift, trial-subtract, restore.
    always_comb begin
        shifted_rem = {rem_reg, dvd_reg[WIDTH-1]};
        trial       = shifted_rem - {1'b0, dsr_reg};
        // The shifted remainder is below 2*divisor, so a set top bit
        // can only come from a borrow, i.e. a negative trial result.
        trial_ok    = ~trial[WIDTH];
        rem_step    = trial_ok ? trial[WIDTH-1:0] : shifted_rem[WIDTH-1:0];
        dvd_shift   = {dvd_reg, trial_ok};
        dvd_step    = dvd_shift[WIDTH-1:0];
        last_step   = (cnt_reg == CW'(WIDTH - 1));
    end

    // Next-state and next-result logic.
    always_comb begin
        state_next = state_reg;
        dvd_next   = dvd_reg;
        dsr_next   = dsr_reg;
        rem_next   = rem_reg;
        cnt_next   = cnt_reg;
        q_next     = q_reg;
        r_next     = r_reg;
        dz_next    = dz_reg;
        zout_next  = zout_reg;

        case (state_reg)
            RUN: begin
                // start is deliberately ignored here.
                rem_next = rem_step;
                dvd_next = dvd_step;
                cnt_next = cnt_reg + CW'(1);
                if (last_step) begin
                    state_next = DONE;
                    q_next     = dvd_step;
                    r_next     = rem_step;
                    dz_next    = 1'b0;
                    zout_next  = (dvd_step == '0);
                end
            end
            default: begin
                // IDLE and DONE both accept a new request; without one,
                // DONE falls back to IDLE and the results keep their values.
                state_next = IDLE;
                if (start) begin
                    dvd_next = A;
                    dsr_next = B;
                    rem_next = '0;
                    cnt_next = '0;
                    if (B == '0) begin
                        state_next = DONE;
                        q_next     = '1;
                        r_next     = A;
                        dz_next    = 1'b1;
                        zout_next  = 1'b0;
                    end else begin
                        // dz of the previous result stays visible until
                        // this division lands in DONE with dz cleared.
                        state_next = RUN;
                    end
                end
            end
        endcase
    end

    // State and result registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            dvd_reg   <= '0;
            dsr_reg   <= '0;
            rem_reg   <= '0;
            cnt_reg   <= '0;
            q_reg     <= '0;
            r_reg     <= '0;
            dz_reg    <= 1'b0;
            zout_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            dvd_reg   <= dvd_next;
            dsr_reg   <= dsr_next;
            rem_reg   <= rem_next;
            cnt_reg   <= cnt_next;
            q_reg     <= q_next;
            r_reg     <= r_next;
            dz_reg    <= dz_next;
            zout_reg  <= zout_next;
        end
    end

    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);
    assign Q    = q_reg;
    assign R    = r_reg;
    assign dz   = dz_reg;
    assign zout = zout_reg;

endmodule

// File: tb/tb_alu_div.sv
// Testbench for alu_div: directed scenarios with literal expectations plus a
// randomized sweep, all checked every cycle against an arithmetic model.
module tb_alu_div;

    localparam int W   = 8;
    localparam int TMO = 50;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] A     = '0;
    logic [W-1:0] B     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] Q;
    logic [W-1:0] R;
    logic         dz;
    logic         zout;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    alu_div #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .A    (A),
        .B    (B),
        .busy (busy),
        .done (done),
        .Q    (Q),
        .R    (R),
        .dz   (dz),
        .zout (zout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a division costs W busy cycles, then one done cycle
    // carrying A/B and A%B; a zero divisor goes straight to done.
    int           run_left = 0;
    bit           m_done   = 1'b0;
    logic [W-1:0] m_q      = '0;
    logic [W-1:0] m_r      = '0;
    bit           m_dz     = 1'b0;
    bit           m_zout   = 1'b1;
    logic [W-1:0] p_q      = '0;
    logic [W-1:0] p_r      = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            run_left <= 0;
            m_done   <= 1'b0;
            m_q      <= '0;
            m_r      <= '0;
            m_dz     <= 1'b0;
            m_zout   <= 1'b1;
        end else if (run_left > 0) begin
            run_left <= run_left - 1;
            m_done   <= (run_left == 1);
            if (run_left == 1) begin
                m_q    <= p_q;
                m_r    <= p_r;
                m_dz   <= 1'b0;
                m_zout <= (p_q == 0);
            end
        end else begin
            m_done <= 1'b0;
            if (start) begin
                if (B == 0) begin
                    m_done <= 1'b1;
                    m_q    <= '1;
                    m_r    <= A;
                    m_dz   <= 1'b1;
                    m_zout <= 1'b0;
                end else begin
                    run_left <= W;
                    p_q      <= A / B;
                    p_r      <= A % B;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy", 32'(busy), 32'(run_left > 0));
            check("done", 32'(done), 32'(m_done));
            check("Q",    32'(Q),    32'(m_q));
            check("R",    32'(R),    32'(m_r));
            check("dz",   32'(dz),   32'(m_dz));
            check("zout", 32'(zout), 32'(m_zout));
        end
    end

    task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        A     = a;
        B     = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
    endtask

    // Called on the negedge right after the accepting edge.
    task automatic wait_done(output int cyc, output int busy_n);
        cyc    = 0;
        busy_n = 0;
        while (!done && cyc < TMO) begin
            if (busy) busy_n++;
            @(negedge clk);
            cyc++;
        end
        check("done_timeout", 32'(done), 32'd1);
    endtask

    int cyc;
    int busy_n;
    int pulses;
    int consec;
    bit prev_done;
    logic [W-1:0] got_q;
    logic [W-1:0] got_r;

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_Q",    32'(Q),    32'd0);
        check("rst_R",    32'(R),    32'd0);
        check("rst_dz",   32'(dz),   32'd0);
        check("rst_zout", 32'(zout), 32'd1);
        rst    = 1'b0;
        cmp_en = 1'b1;

        // 200 / 7
        do_start(8'd200, 8'd7);
        wait_done(cyc, busy_n);
        $display("op 200/7: Q=%0d R=%0d dz=%0d zout=%0d busy_cycles=%0d", Q, R, dz, zout, busy_n);
        check("t1_busy_cycles", 32'(busy_n), 32'd8);
        check("t1_latency",     32'(cyc),    32'd8);
        check("t1_Q",    32'(Q),    32'd28);
        check("t1_R",    32'(R),    32'd4);
        check("t1_dz",   32'(dz),   32'd0);
        check("t1_zout", 32'(zout), 32'd0);

        // 255 / 1 then 5 / 9
        do_start(8'd255, 8'd1);
        wait_done(cyc, busy_n);
        $display("op 255/1: Q=%0d R=%0d", Q, R);
        check("t2_Q", 32'(Q), 32'd255);
        check("t2_R", 32'(R), 32'd0);
        do_start(8'd5, 8'd9);
        wait_done(cyc, busy_n);
        $display("op 5/9: Q=%0d R=%0d zout=%0d", Q, R, zout);
        check("t3_Q",    32'(Q),    32'd0);
        check("t3_R",    32'(R),    32'd5);
        check("t3_zout", 32'(zout), 32'd1);

        // 77 / 0
        do_start(8'd77, 8'd0);
        wait_done(cyc, busy_n);
        $display("op 77/0: Q=%0d R=%0d dz=%0d", Q, R, dz);
        check("t4_latency", 32'(cyc),    32'd0);
        check("t4_busy",    32'(busy_n), 32'd0);
        check("t4_dz",      32'(dz),     32'd1);
        check("t4_Q",       32'(Q),      32'd255);
        check("t4_R",       32'(R),      32'd77);

        // start pulsed in RUN is ignored
        do_start(8'd100, 8'd9);
        repeat (2) @(negedge clk);
        A     = 8'd10;
        B     = 8'd3;
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                pulses++;
                got_q = Q;
                got_r = R;
            end
            @(negedge clk);
        end
        $display("op 100/9 with ignored 10/3: Q=%0d R=%0d pulses=%0d", got_q, got_r, pulses);
        check("t5_pulses", 32'(pulses), 32'd1);
        check("t5_Q",      32'(got_q),  32'd11);
        check("t5_R",      32'(got_r),  32'd1);

        // reset between edges during RUN
        do_start(8'd50, 8'd3);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        $display("mid-run reset: busy=%0d done=%0d Q=%0d R=%0d dz=%0d zout=%0d", busy, done, Q, R, dz, zout);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_Q",    32'(Q),    32'd0);
        check("t6_R",    32'(R),    32'd0);
        check("t6_dz",   32'(dz),   32'd0);
        check("t6_zout", 32'(zout), 32'd1);
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        check("t6_no_done", 32'(pulses), 32'd0);
        do_start(8'd9, 8'd2);
        wait_done(cyc, busy_n);
        $display("op 9/2 after reset: Q=%0d R=%0d", Q, R);
        check("t6_Q2", 32'(Q), 32'd4);
        check("t6_R2", 32'(R), 32'd1);

        // start held high: back-to-back operations, 9 cycles each
        @(negedge clk);
        start     = 1'b1;
        pulses    = 0;
        consec    = 0;
        prev_done = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            A = $urandom;
            B = 8'($urandom_range(1, 255));
            @(negedge clk);
            if (done) begin
                pulses++;
                $display("back-to-back op: Q=%0d R=%0d", Q, R);
            end
            if (done && prev_done) consec++;
            prev_done = done;
        end
        start = 1'b0;
        check("t7_pulses", 32'(pulses), 32'd4);
        check("t7_consec", 32'(consec), 32'd0);

        // random sweep, start also toggling during RUN and DONE
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       A = '0;
                1:       A = '1;
                default: A = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       B = '0;
                1:       B = 8'd1;
                2:       B = '1;
                default: B = $urandom;
            endcase
            start = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            if (done) $display("random op: Q=%0d R=%0d dz=%0d zout=%0d", Q, R, dz, zout);
        end
        start = 1'b0;
        repeat (12) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
